decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
- Parametrised, registered instruction-decode stage for the pipelined ARM64 core; successor to the combinational decode.
- Owns the register file, decodes operands/immediates/branch target/MOV mask, and registers results into the ID/EX boundary.
- Adds a valid/ready handshake, flush, load-use stall, and zero-register handling.

Parameters:
DATA_W, 64, register/datapath width (also PC width)
NUM_REGS, 32, register count; index NUM_REGS-1 is the zero register (XZR)
ADDR_W, $clog2(NUM_REGS), register index width (derived, not overridden)

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
in_valid  in  1  instruction_i/PC_i/controls valid
in_ready  out  1  stage accepts this cycle
instruction_i  in  32  ARM instruction
PC_i  in  DATA_W  PC of instruction_i
Reg2Loc  in  1  0: read port B = Rd [4:0]; 1: Rm [20:16]
UncondBr  in  1  1: BrAddr26; 0: CondAddr19
flush  in  1  kill held output and incoming instruction
ex_load  in  1  instruction in EX is a load
ex_rd  in  ADDR_W  destination of that load
wb_en  in  1  register write enable
wb_addr  in  ADDR_W  write register
wb_data  in  DATA_W  write data
out_valid  out  1  registered outputs valid
out_ready  in  1  EX accepts
instruction_o  out  32  registered instruction
PC_o  out  DATA_W  registered PC
Da  out  DATA_W  reg[Rn]
Db  out  DATA_W  reg[Reg2 address]
ALU_Imm  out  DATA_W  zero-extended [21:10]
DT_Address  out  DATA_W  sign-extended [20:12]
BrAdder_o  out  DATA_W  PC_i + (sext(selected offset) << 2), modulo 2^DATA_W
MOVmask_o  out  DATA_W  all ones except 16-bit zero field at shamt [22:21]*16
Rn_o, Rb_o, Rd_o  out  ADDR_W  registered register indices (for forwarding)

Behaviour:
- Reset (reset_n low at posedge): out_valid=0, all registered outputs 0, all registers 0; in_ready=0 while reset_n low.
- hazard = ex_load && ex_rd != XZR && (ex_rd == Rn || ex_rd == Reg2 address); combinational on the current instruction_i.
- in_ready = reset_n && !flush && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): next posedge loads all output registers from this cycle's decode; out_valid=1. Latency 1 cycle.
- Output side: out_valid && !out_ready holds every output stable; in_ready=0.
- Hazard with free or draining output: bubble inserted, out_valid=0 next cycle; instruction_i must be held by upstream until accepted.
- Flush: out_valid=0 next posedge regardless of out_ready/hazard; the incoming instruction is discarded. Flush dominates accept.
- Register file:
  - write at posedge when wb_en && wb_addr != XZR; writes to XZR ignored; reads of XZR return 0.
  - wb_addr >= NUM_REGS (non-power-of-two NUM_REGS) ignored on write; reads of such indices return 0.
- Reset mid-stall or mid-hold: reset wins; held instruction lost.
- Simultaneous wb write and accept: behaviour governed by optional feature.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined: reads see same-cycle wb_data when wb_en && wb_addr matches the read index (not XZR); captured Da/Db carry the new value.
- Undefined: reads return pre-write contents; the upstream writeback stage must be a half-cycle earlier or forwarded in EX.

Decomposition:
- Package decode_pkg:
  - instruction field bit positions (Rd, Rn, Rm, imm12, addr9, cond19, br26, movshamt)
  - XZR index function of NUM_REGS
  - typedef struct for the ID/EX payload
- Sub-module decode_regfile: NUM_REGS x DATA_W, two read ports, one write port, sync reset, XZR rule, bypass under the macro.
- Decode/extend logic stays inline.

Test Plan:
- Reset then accept "B -7" at PC_i=0x100, UncondBr=1, out_ready=1 -> one cycle later out_valid=1, BrAdder_o=0xE4.
- Accept "MOVK X1,#0xDEAD,LSL 32" while out_ready=0 for 3 cycles -> MOVmask_o=FFFF_0000_FFFF_FFFF held; in_ready=0 each cycle; single transfer on release.
- Write X0=1738, X2=-15; then ex_load=1, ex_rd=2, instruction Rn=0, Reg2Loc=0, Rd=2 -> in_ready=0, bubble (out_valid=0). Drop ex_load -> Da=1738, Db=0xFFFF_FFFF_FFFF_FFF1.
- wb_en writing 999 to X31, then read X31 -> Da=0; ex_load with ex_rd=31 -> no stall.
- With DECODE_WB_BYPASS_EN: write X1=42069 and accept Reg2Loc=1, Rm=1 in the same cycle -> Db=42069. Without the macro -> Db equals prior value 0.
- flush asserted with in_valid=1 and a held out_valid=1 -> out_valid=0 next cycle; the flushed instruction never appears.

Source files
------------

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Brief    : Shared instruction field positions, XZR helper and ID/EX payload.
// Revision : 1.0
// ============================================================================
package decode_pkg;

    localparam int c_FIELD_W       = 5;
    localparam int c_RD_LSB        = 0;
    localparam int c_RN_LSB        = 5;
    localparam int c_RM_LSB        = 16;
    localparam int c_IMM12_LSB     = 10;
    localparam int c_IMM12_W       = 12;
    localparam int c_ADDR9_LSB     = 12;
    localparam int c_ADDR9_W       = 9;
    localparam int c_COND19_LSB    = 5;
    localparam int c_COND19_W      = 19;
    localparam int c_BR26_LSB      = 0;
    localparam int c_BR26_W        = 26;
    localparam int c_MOVSHAMT_LSB  = 21;
    localparam int c_MOVSHAMT_W    = 2;

    // The highest register index is the hard-wired zero register.
    function automatic int xzr_index(input int num_regs);
        return num_regs - 1;
    endfunction

    typedef struct packed {
        logic [31:0]          instruction;
        logic [c_FIELD_W-1:0] rn;
        logic [c_FIELD_W-1:0] rb;
        logic [c_FIELD_W-1:0] rd;
    } id_ex_ctl_t;

endpackage : decode_pkg
`default_nettype wire

// File: rtl/decode_regfile.sv
`default_nettype none
// ============================================================================
// Module   : decode_regfile
// Brief    : 2R/1W register file with zero register; same-cycle write bypass
//            on reads when DECODE_WB_BYPASS_EN is defined.
// Revision : 1.0
// ============================================================================
module decode_regfile
    import decode_pkg::*;
#(
    parameter  int DATA_W   = 64,
    parameter  int NUM_REGS = 32,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              i_reset_n,
    input  logic [ADDR_W-1:0] i_ra_addr,
    input  logic [ADDR_W-1:0] i_rb_addr,
    output logic [DATA_W-1:0] o_ra_data,
    output logic [DATA_W-1:0] o_rb_data,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata
);

    localparam logic [ADDR_W-1:0] c_XZR = ADDR_W'(xzr_index(NUM_REGS));
    localparam logic [ADDR_W:0]   c_NUM = (ADDR_W+1)'(NUM_REGS);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_we;

    assign w_we = i_we && (i_waddr != c_XZR) && ({1'b0, i_waddr} < c_NUM);

    always_ff @(posedge clk) begin
        if (!i_reset_n) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else if (w_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = '0;
        if ((addr != c_XZR) && ({1'b0, addr} < c_NUM)) begin
            v = r_regs[addr];
        end
`ifdef DECODE_WB_BYPASS_EN
        if (w_we && (i_waddr == addr)) begin
            v = i_wdata;
        end
`endif
        return v;
    endfunction

    assign o_ra_data = read_port(i_ra_addr);
    assign o_rb_data = read_port(i_rb_addr);

endmodule : decode_regfile
`default_nettype wire

// File: rtl/decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage_pipe
// Brief    : Registered ARM64 decode stage with valid/ready, flush, load-use
//            stall and XZR handling. Optional macro: DECODE_WB_BYPASS_EN.
// Revision : 1.0
// ============================================================================
module decode_stage_pipe
    import decode_pkg::*;
#(
    parameter  int DATA_W   = 64,
    parameter  int NUM_REGS = 32,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction_i,
    input  logic [DATA_W-1:0] PC_i,
    input  logic              Reg2Loc,
    input  logic              UncondBr,
    input  logic              flush,
    input  logic              ex_load,
    input  logic [ADDR_W-1:0] ex_rd,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instruction_o,
    output logic [DATA_W-1:0] PC_o,
    output logic [DATA_W-1:0] Da,
    output logic [DATA_W-1:0] Db,
    output logic [DATA_W-1:0] ALU_Imm,
    output logic [DATA_W-1:0] DT_Address,
    output logic [DATA_W-1:0] BrAdder_o,
    output logic [DATA_W-1:0] MOVmask_o,
    output logic [ADDR_W-1:0] Rn_o,
    output logic [ADDR_W-1:0] Rb_o,
    output logic [ADDR_W-1:0] Rd_o
);

    localparam logic [ADDR_W-1:0] c_XZR = ADDR_W'(xzr_index(NUM_REGS));

    logic [c_FIELD_W-1:0] w_rn_f;
    logic [c_FIELD_W-1:0] w_rm_f;
    logic [c_FIELD_W-1:0] w_rd_f;
    logic [c_FIELD_W-1:0] w_rb_f;
    logic [ADDR_W-1:0]    w_rn;
    logic [ADDR_W-1:0]    w_rb;
    logic                 w_hazard;
    logic                 w_accept;
    logic [DATA_W-1:0]    w_da;
    logic [DATA_W-1:0]    w_db;
    logic [DATA_W-1:0]    w_alu_imm;
    logic [DATA_W-1:0]    w_dt_addr;
    logic [DATA_W-1:0]    w_br_off;
    logic [DATA_W-1:0]    w_br_target;
    logic [5:0]           w_mov_shift;
    logic [DATA_W-1:0]    w_mov_mask;
    id_ex_ctl_t           r_ctl;

    assign w_rn_f = instruction_i[c_RN_LSB +: c_FIELD_W];
    assign w_rm_f = instruction_i[c_RM_LSB +: c_FIELD_W];
    assign w_rd_f = instruction_i[c_RD_LSB +: c_FIELD_W];
    assign w_rb_f = Reg2Loc ? w_rm_f : w_rd_f;
    assign w_rn   = w_rn_f[ADDR_W-1:0];
    assign w_rb   = w_rb_f[ADDR_W-1:0];

    // A load writing XZR produces nothing to wait for.
    assign w_hazard = ex_load && (ex_rd != c_XZR) && ((ex_rd == w_rn) || (ex_rd == w_rb));
    assign in_ready = reset_n && !flush && !w_hazard && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    decode_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk       (clk),
        .i_reset_n (reset_n),
        .i_ra_addr (w_rn),
        .i_rb_addr (w_rb),
        .o_ra_data (w_da),
        .o_rb_data (w_db),
        .i_we      (wb_en),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data)
    );

    assign w_alu_imm = DATA_W'(instruction_i[c_IMM12_LSB +: c_IMM12_W]);
    assign w_dt_addr = {{(DATA_W-c_ADDR9_W){instruction_i[c_ADDR9_LSB+c_ADDR9_W-1]}},
                        instruction_i[c_ADDR9_LSB +: c_ADDR9_W]};

    always_comb begin
        w_br_off = {{(DATA_W-c_COND19_W){instruction_i[c_COND19_LSB+c_COND19_W-1]}},
                    instruction_i[c_COND19_LSB +: c_COND19_W]};
        if (UncondBr) begin
            w_br_off = {{(DATA_W-c_BR26_W){instruction_i[c_BR26_LSB+c_BR26_W-1]}},
                        instruction_i[c_BR26_LSB +: c_BR26_W]};
        end
    end

    assign w_br_target = PC_i + (w_br_off << 2);
    assign w_mov_shift = {instruction_i[c_MOVSHAMT_LSB +: c_MOVSHAMT_W], 4'b0000};
    assign w_mov_mask  = ~({{(DATA_W-16){1'b0}}, 16'hFFFF} << w_mov_shift);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid  <= 1'b0;
            r_ctl      <= '0;
            PC_o       <= '0;
            Da         <= '0;
            Db         <= '0;
            ALU_Imm    <= '0;
            DT_Address <= '0;
            BrAdder_o  <= '0;
            MOVmask_o  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_accept) begin
            out_valid         <= 1'b1;
            r_ctl.instruction <= instruction_i;
            r_ctl.rn          <= w_rn_f;
            r_ctl.rb          <= w_rb_f;
            r_ctl.rd          <= w_rd_f;
            PC_o              <= PC_i;
            Da                <= w_da;
            Db                <= w_db;
            ALU_Imm           <= w_alu_imm;
            DT_Address        <= w_dt_addr;
            BrAdder_o         <= w_br_target;
            MOVmask_o         <= w_mov_mask;
        end else if (out_ready) begin
            // Drained with nothing accepted (idle or load-use bubble).
            out_valid <= 1'b0;
        end
    end

    assign instruction_o = r_ctl.instruction;
    assign Rn_o          = r_ctl.rn[ADDR_W-1:0];
    assign Rb_o          = r_ctl.rb[ADDR_W-1:0];
    assign Rd_o          = r_ctl.rd[ADDR_W-1:0];

endmodule : decode_stage_pipe
`default_nettype wire

// File: tb/tb_decode_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage_pipe
// Brief    : Directed vector table plus hand sequences for decode_stage_pipe.
// Revision : 1.0
// ============================================================================
module tb_decode_stage_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_i;
    logic [63:0] PC_i;
    logic        Reg2Loc;
    logic        UncondBr;
    logic        flush;
    logic        ex_load;
    logic [4:0]  ex_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_o;
    logic [63:0] PC_o, Da, Db, ALU_Imm, DT_Address, BrAdder_o, MOVmask_o;
    logic [4:0]  Rn_o, Rb_o, Rd_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_xfer   = 0;

    always #5 clk = ~clk;

    decode_stage_pipe #(.DATA_W(64), .NUM_REGS(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instruction_i (instruction_i),
        .PC_i          (PC_i),
        .Reg2Loc       (Reg2Loc),
        .UncondBr      (UncondBr),
        .flush         (flush),
        .ex_load       (ex_load),
        .ex_rd         (ex_rd),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .instruction_o (instruction_o),
        .PC_o          (PC_o),
        .Da            (Da),
        .Db            (Db),
        .ALU_Imm       (ALU_Imm),
        .DT_Address    (DT_Address),
        .BrAdder_o     (BrAdder_o),
        .MOVmask_o     (MOVmask_o),
        .Rn_o          (Rn_o),
        .Rb_o          (Rb_o),
        .Rd_o          (Rd_o)
    );

    always @(posedge clk) begin
        if (out_valid && out_ready) n_xfer <= n_xfer + 1;
    end

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
        logic        reg2loc;
        logic        uncond;
        logic [63:0] da, db, alu, dt, br, mov;
        logic [4:0]  rn, rb, rd;
    } vec_t;

    vec_t vecs[4];

    localparam logic [31:0] c_MOVK = 32'hF2DB_D5A1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [63:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    initial begin
        int x0;
        vecs[0] = '{instr:32'h17FF_FFF9, pc:64'h100,  reg2loc:1'b0, uncond:1'b1,
                    da:64'd0, db:64'd0, alu:64'hFFF, dt:64'hFFFF_FFFF_FFFF_FFFF,
                    br:64'hE4, mov:64'h0000_FFFF_FFFF_FFFF, rn:5'd31, rb:5'd25, rd:5'd25};
        vecs[1] = '{instr:32'h0004_8C03, pc:64'h1000, reg2loc:1'b1, uncond:1'b0,
                    da:64'd1738, db:64'h55, alu:64'h123, dt:64'h48,
                    br:64'hA180, mov:64'hFFFF_FFFF_FFFF_0000, rn:5'd0, rb:5'd4, rd:5'd3};
        vecs[2] = '{instr:32'hB4FF_FFE2, pc:64'h2000, reg2loc:1'b0, uncond:1'b0,
                    da:64'd0, db:64'hFFFF_FFFF_FFFF_FFF1, alu:64'hFFF, dt:64'hFFFF_FFFF_FFFF_FFFF,
                    br:64'h1FFC, mov:64'h0000_FFFF_FFFF_FFFF, rn:5'd31, rb:5'd2, rd:5'd2};
        vecs[3] = '{instr:c_MOVK, pc:64'h3000, reg2loc:1'b0, uncond:1'b1,
                    da:64'd0, db:64'd0, alu:64'h6F5, dt:64'hFFFF_FFFF_FFFF_FFBD,
                    br:64'hFFFF_FFFF_FB6F_8684, mov:64'hFFFF_0000_FFFF_FFFF, rn:5'd13, rb:5'd1, rd:5'd1};

        reset_n = 1'b0; in_valid = 1'b0; instruction_i = '0; PC_i = '0;
        Reg2Loc = 1'b0; UncondBr = 1'b0; flush = 1'b0; ex_load = 1'b0; ex_rd = '0;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; out_ready = 1'b1;
        tick(); tick();
        chk("reset_in_ready", {63'd0, in_ready}, 64'd0);
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_Da", Da, 64'd0);
        chk("reset_MOVmask", MOVmask_o, 64'd0);
        reset_n = 1'b1;
        tick();

        wb_write(5'd0, 64'd1738);
        wb_write(5'd2, 64'hFFFF_FFFF_FFFF_FFF1);
        wb_write(5'd4, 64'h55);

        for (int i = 0; i < 4; i++) begin
            instruction_i = vecs[i].instr; PC_i = vecs[i].pc;
            Reg2Loc = vecs[i].reg2loc; UncondBr = vecs[i].uncond;
            in_valid = 1'b1; out_ready = 1'b1;
            #1;
            chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, 64'd1);
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, 64'd1);
            chk($sformatf("v%0d_instr", i), {32'd0, instruction_o}, {32'd0, vecs[i].instr});
            chk($sformatf("v%0d_PC", i), PC_o, vecs[i].pc);
            chk($sformatf("v%0d_Da", i), Da, vecs[i].da);
            chk($sformatf("v%0d_Db", i), Db, vecs[i].db);
            chk($sformatf("v%0d_ALU_Imm", i), ALU_Imm, vecs[i].alu);
            chk($sformatf("v%0d_DT_Address", i), DT_Address, vecs[i].dt);
            chk($sformatf("v%0d_BrAdder", i), BrAdder_o, vecs[i].br);
            chk($sformatf("v%0d_MOVmask", i), MOVmask_o, vecs[i].mov);
            chk($sformatf("v%0d_Rn", i), {59'd0, Rn_o}, {59'd0, vecs[i].rn});
            chk($sformatf("v%0d_Rb", i), {59'd0, Rb_o}, {59'd0, vecs[i].rb});
            chk($sformatf("v%0d_Rd", i), {59'd0, Rd_o}, {59'd0, vecs[i].rd});
        end
        tick();
        chk("drain_out_valid", {63'd0, out_valid}, 64'd0);

        // Load-use hazard: stall, bubble, then release
        instruction_i = 32'h0000_0002; Reg2Loc = 1'b0; UncondBr = 1'b0; PC_i = 64'h400;
        in_valid = 1'b1; ex_load = 1'b1; ex_rd = 5'd2;
        #1;
        chk("hazard_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        chk("hazard_bubble", {63'd0, out_valid}, 64'd0);
        ex_load = 1'b0;
        #1;
        chk("hazard_release_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        chk("hazard_out_valid", {63'd0, out_valid}, 64'd1);
        chk("hazard_Da", Da, 64'd1738);
        chk("hazard_Db", Db, 64'hFFFF_FFFF_FFFF_FFF1);

        // XZR: writes ignored, reads zero, no stall on ex_rd=31
        wb_write(5'd31, 64'd999);
        instruction_i = 32'h0000_03E0; Reg2Loc = 1'b0; in_valid = 1'b1;
        ex_load = 1'b1; ex_rd = 5'd31;
        #1;
        chk("xzr_no_stall", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0; ex_load = 1'b0;
        chk("xzr_Da", Da, 64'd0);
        chk("xzr_Db", Db, 64'd1738);

        // Writeback coincident with accept
        instruction_i = 32'h0001_0000; Reg2Loc = 1'b1; in_valid = 1'b1;
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 64'd42069;
        tick();
        wb_en = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
        chk("wb_same_cycle_Db", Db, 64'd42069);
`else
        chk("wb_same_cycle_Db", Db, 64'd0);
`endif
        tick();
        in_valid = 1'b0;
        chk("wb_after_Db", Db, 64'd42069);
        tick();

        // Output back-pressure holds MOVK for 3 cycles, one transfer on release
        out_ready = 1'b0; Reg2Loc = 1'b0; UncondBr = 1'b0; PC_i = 64'h500;
        instruction_i = c_MOVK; in_valid = 1'b1;
        tick();
        instruction_i = 32'h0004_8C03;
        x0 = n_xfer;
        chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("hold%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
            tick();
            chk($sformatf("hold%0d_MOVmask", c), MOVmask_o, 64'hFFFF_0000_FFFF_FFFF);
            chk($sformatf("hold%0d_instr", c), {32'd0, instruction_o}, {32'd0, c_MOVK});
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        chk("hold_released", {63'd0, out_valid}, 64'd0);
        tick();
        chk("hold_single_xfer", 64'(n_xfer - x0), 64'd1);

        // Flush kills held output and incoming instruction
        out_ready = 1'b0; instruction_i = c_MOVK; in_valid = 1'b1;
        tick();
        chk("flush_pre_valid", {63'd0, out_valid}, 64'd1);
        instruction_i = 32'h0004_8C03; flush = 1'b1;
        #1;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        tick();
        chk("flush_never_appears", {63'd0, out_valid}, 64'd0);

        // Reset during a hold wins and clears the register file
        out_ready = 1'b0; instruction_i = c_MOVK; in_valid = 1'b1;
        tick();
        reset_n = 1'b0;
        tick();
        chk("rst_hold_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_hold_MOVmask", MOVmask_o, 64'd0);
        chk("rst_hold_in_ready", {63'd0, in_ready}, 64'd0);
        reset_n = 1'b1; out_ready = 1'b1; instruction_i = 32'h0000_0002;
        tick();
        in_valid = 1'b0;
        chk("rst_regs_Db", Db, 64'd0);
        chk("rst_regs_valid", {63'd0, out_valid}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_decode_stage_pipe
`default_nettype wire
